// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-side SRAM-like slave with local memory and in-order delayed responses
// Memory is accessed at accept; the response queue only carries data and a countdown per entry.
module data_sram_responder #(
   parameter int MEM_AW = 12,
   parameter int OUTST  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   input  logic [3:0]  resp_delay,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int PW    = (OUTST > 1) ? $clog2(OUTST) : 1;
   localparam int CW    = $clog2(OUTST + 1);
   localparam int DEPTH = 1 << MEM_AW;

   logic [31:0]       mem [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [3:0]        ent_cnt  [OUTST];
   logic [31:0]       ent_data [OUTST];
   logic              ent_wr   [OUTST];

   logic [MEM_AW-1:0] idx;
   logic [3:0]        eff_delay;
   logic              accept;
   logic              retire;
   logic              unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   assign idx         = data_sram_addr[MEM_AW+1:2];
   assign eff_delay   = (resp_delay == 4'd0) ? 4'd1 : resp_delay;
   assign unused_bits = &{1'b0, data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

   // A retire in the same cycle does not free a slot for acceptance.
   assign data_sram_addr_ok = !reset && (count < CW'(OUTST));
   assign accept            = data_sram_req && data_sram_addr_ok;

   assign data_sram_data_ok = (count != '0) && (ent_cnt[head] == 4'd1);
   assign retire            = data_sram_data_ok;
   assign data_sram_rdata   = (data_sram_data_ok && !ent_wr[head]) ? ent_data[head] : 32'd0;

   always_ff @(posedge clk) begin
      if (accept && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i]) begin
               mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < OUTST; i++) begin
            ent_cnt[i]  <= 4'd0;
            ent_data[i] <= 32'd0;
            ent_wr[i]   <= 1'b0;
         end
      end else begin
         // Every entry counts down in parallel and parks at 1 until it reaches the head.
         for (int i = 0; i < OUTST; i++) begin
            if (ent_cnt[i] > 4'd1) begin
               ent_cnt[i] <= ent_cnt[i] - 4'd1;
            end
         end
         if (retire) begin
            ent_cnt[head] <= 4'd0;
            head          <= ptr_inc(head);
         end
         if (accept) begin
            ent_wr[tail]   <= data_sram_wr;
            ent_data[tail] <= data_sram_wr ? 32'd0 : mem[idx];
            ent_cnt[tail]  <= eff_delay;
            tail           <= ptr_inc(tail);
         end
         case ({accept, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
